// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the barrel-threaded RV32 core.
// Holds the result-select encodings used by decode, hazard and writeback,
// and the helper that derives the thread-ID width from the thread count.
package pipeline_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    // Thread-ID width for a power-of-two thread count (>= 2).
    function automatic int bits_threads(input int num_threads);
        return $clog2(num_threads);
    endfunction

endpackage

// File: rtl/retire_counters.sv
// Per-thread retired-instruction counters.
// Ports:
//   clk, reset       clock, synchronous active-high reset (all counters to 0)
//   inc, inc_tid     increment counter[inc_tid] by one (wraps modulo 2^COUNTER_WIDTH)
//   clr, clr_tid     clear counter[clr_tid]; wins over an increment of the same thread
//   rd_tid, value    combinational read of counter[rd_tid]
module retire_counters
    import pipeline_pkg::*;
#(
    parameter int NUM_THREADS   = 4,
    parameter int COUNTER_WIDTH = 32,
    localparam int BITS_THREADS = bits_threads(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic [BITS_THREADS-1:0]  inc_tid,
    input  logic                     clr,
    input  logic [BITS_THREADS-1:0]  clr_tid,
    input  logic [BITS_THREADS-1:0]  rd_tid,
    output logic [COUNTER_WIDTH-1:0] value
);

    logic [COUNTER_WIDTH-1:0] cnt [NUM_THREADS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (clr && (clr_tid == BITS_THREADS'(i))) begin
                cnt[i] <= '0;
            end else if (inc && (inc_tid == BITS_THREADS'(i))) begin
                cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
            end
        end
    end

    assign value = cnt[rd_tid];

endmodule

// File: rtl/writeback.sv
// Write-back (W) stage of the barrel-threaded RV32 pipeline.
// Registers the M-stage outputs, selects the write-back result on the M side
// so result_w is a plain flop output, drives the register-file write port /
// forwarding path, and keeps one retired-instruction counter per thread.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_m .. tid_m           M-stage instruction fields
//   valid_w .. tid_w           registered W-stage outputs (register-file write port)
//   cnt_clr, cnt_tid           clear / select a retire counter
//   cnt_value                  retire count of thread cnt_tid (combinational)
module writeback
    import pipeline_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_THREADS   = 4,
    parameter int COUNTER_WIDTH = 32,
    localparam int BITS_THREADS = bits_threads(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_m,
    input  logic                     reg_write_m,
    input  logic [1:0]               result_src_m,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    read_data_m,
    input  logic [4:0]               rd_m,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    input  logic [BITS_THREADS-1:0]  tid_m,
    output logic                     valid_w,
    output logic                     reg_write_w,
    output logic [4:0]               rd_w,
    output logic [DATA_WIDTH-1:0]    result_w,
    output logic [BITS_THREADS-1:0]  tid_w,
    input  logic                     cnt_clr,
    input  logic [BITS_THREADS-1:0]  cnt_tid,
    output logic [COUNTER_WIDTH-1:0] cnt_value
);

    logic [DATA_WIDTH-1:0] pc4_ext;
    logic [DATA_WIDTH-1:0] result_m;

    // PC+4 is fitted to the data width: zero-extended or truncated.
    generate
        if (ADDRESS_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
            assign pc4_ext = pc_plus4_m[DATA_WIDTH-1:0];
        end else begin : g_pc_ext
            assign pc4_ext = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, pc_plus4_m};
        end
    endgenerate

    always_comb begin
        result_m = '0;
        case (result_src_m)
            RESULT_ALU: result_m = alu_result_m;
            RESULT_MEM: result_m = read_data_m;
            RESULT_PC4: result_m = pc4_ext;
            default:    result_m = '0;
        endcase
    end

    // result_w is captured unconditionally; consumers qualify it with reg_write_w.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            rd_w        <= '0;
            result_w    <= '0;
            tid_w       <= '0;
        end else begin
            valid_w     <= valid_m;
            reg_write_w <= reg_write_m & valid_m & (rd_m != 5'd0);
            rd_w        <= rd_m;
            result_w    <= result_m;
            tid_w       <= tid_m;
        end
    end

    // An instruction retires on the edge that moves it out of W.
    retire_counters #(
        .NUM_THREADS   (NUM_THREADS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_retire_counters (
        .clk     (clk),
        .reset   (reset),
        .inc     (valid_w),
        .inc_tid (tid_w),
        .clr     (cnt_clr),
        .clr_tid (cnt_tid),
        .rd_tid  (cnt_tid),
        .value   (cnt_value)
    );

endmodule
